// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the execute stage and a word-wide
// data RAM. It turns byte/half/word requests into whole-word RAM accesses.
// Sub-word stores use a read-modify-write sequence that takes two cycles.
// Loads are extended and registered.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake; ready is low while in WRITE
//   req_we, req_size    store/load select; size 00 byte, 01 half, 1x word
//   req_unsigned        loads only: zero-extend instead of sign-extend
//   req_addr, req_wdata byte address; right-aligned store data
//   load_data/valid     registered extended load result plus 1-cycle pulse
//   misalign, bad_addr  1-cycle reject pulse; address of last misaligned request
//   stall               inverse of req_ready
//   ram_addr/wdata/we   word-aligned RAM access (combinational)
//   ram_rdata           combinational RAM read data at ram_addr
module mem_access_unit #(
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic [31:0] bad_addr,
  output logic        stall,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned DW     = 32;
  localparam int unsigned PAD_W  = DW - ADDR_W;
  localparam bit          BE_ORD = (BIG_ENDIAN != 0);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic          load_valid_q, load_valid_d;
  logic          misalign_q, misalign_d;
  logic [DW-1:0] bad_addr_q, bad_addr_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [DW-1:0] waddr_q, waddr_d;

  logic          accept_c;
  logic          is_word_c;
  logic          is_half_c;
  logic          misal_c;
  logic [1:0]    lane_c;
  logic [4:0]    shift_c;
  logic [DW-1:0] mask_c;
  logic [DW-1:0] lane_rdata_c;
  logic [DW-1:0] merged_c;
  logic [DW-1:0] ext_c;
  logic [DW-1:0] word_addr_c;
  logic          ram_we_c;

  // Request decode: alignment, lane selection and word address.
  always_comb begin
    is_word_c   = req_size[1];
    is_half_c   = (req_size == 2'b01);
    word_addr_c = {{PAD_W{1'b0}}, req_addr[ADDR_W-1:2], 2'b00};
    misal_c     = is_word_c ? (req_addr[1:0] != 2'b00) : (is_half_c & req_addr[0]);
    // Big-endian mirrors the lane: byte a -> lane 3-a, half a -> lane 2-a.
    if (is_half_c) begin
      lane_c = BE_ORD ? (req_addr[1:0] ^ 2'b10) : req_addr[1:0];
    end else begin
      lane_c = BE_ORD ? ~req_addr[1:0] : req_addr[1:0];
    end
    shift_c = {lane_c, 3'b000};
    mask_c  = is_half_c ? 32'h0000_FFFF : 32'h0000_00FF;
  end

  // Load extraction/extension and sub-word store merge.
  always_comb begin
    lane_rdata_c = ram_rdata >> shift_c;
    merged_c     = (ram_rdata & ~(mask_c << shift_c)) | ((req_wdata & mask_c) << shift_c);
    if (is_word_c) begin
      ext_c = ram_rdata;
    end else if (is_half_c) begin
      ext_c = {{16{~req_unsigned & lane_rdata_c[15]}}, lane_rdata_c[15:0]};
    end else begin
      ext_c = {{24{~req_unsigned & lane_rdata_c[7]}}, lane_rdata_c[7:0]};
    end
  end

  assign accept_c = req_valid & (state_q == IDLE);

  // Next-state and RAM-side outputs.
  always_comb begin
    state_d      = state_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    bad_addr_d   = bad_addr_q;
    merge_d      = merge_q;
    waddr_d      = waddr_q;
    req_ready    = 1'b1;
    ram_addr     = word_addr_c;
    ram_wdata    = req_wdata;
    ram_we_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (misal_c) begin
            misalign_d = 1'b1;
            bad_addr_d = req_addr;
          end else if (!req_we) begin
            load_data_d  = ext_c;
            load_valid_d = 1'b1;
          end else if (is_word_c) begin
            ram_we_c = 1'b1;
          end else begin
            merge_d = merged_c;
            waddr_d = word_addr_c;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        req_ready = 1'b0;
        ram_addr  = waddr_q;
        ram_wdata = merge_q;
        ram_we_c  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset blocks the write strobe combinationally, even mid-WRITE.
  assign ram_we     = ram_we_c & ~rst;
  assign stall      = ~req_ready;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;
  assign bad_addr   = bad_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bad_addr_q   <= '0;
      merge_q      <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      bad_addr_q   <= bad_addr_d;
      merge_q      <= merge_d;
      waddr_q      <= waddr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word behavioural RAM.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic [31:0] bad_addr;
  logic        stall;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.BIG_ENDIAN(0), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .load_data(load_data), .load_valid(load_valid),
    .misalign(misalign), .bad_addr(bad_addr), .stall(stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[6:2]];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[6:2]] <= ram_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b0;
    pre_we    = 1'b1;
    pre_idx   = idx;
    pre_data  = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state, with a word store presented while reset is high.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = 32'h10;
    req_wdata = 32'h1111_1111;
    #1;
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_load_data", load_data, 0);
    check("rst_load_valid", 32'(load_valid), 0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_bad_addr", bad_addr, 0);
    check("rst_ready", 32'(req_ready), 1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // SW then LW.
    drive(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_ram_we", 32'(ram_we), 1);
    check("sw_ram_addr", ram_addr, 32'h10);
    check("sw_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("sw_stall", 32'(stall), 0);
    check("ram_addr_hi", 32'(ram_addr[31:7]), 0);
    check("ram_addr_lsb", 32'(ram_addr[1:0]), 0);
    tick();
    check("sw_one_cycle_stall", 32'(stall), 0);
    idle();
    check("sw_we_drop", 32'(ram_we), 0);
    check("sw_mem", mem[4], 32'hDEAD_BEEF);
    drive(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    tick();
    check("lw_valid", 32'(load_valid), 1);
    check("lw_data", load_data, 32'hDEAD_BEEF);
    idle();
    tick();
    check("lw_pulse_end", 32'(load_valid), 0);

    // SB 0x80 @0x13 over 0x11223344; a request presented during WRITE is ignored.
    preload(5'd4, 32'h1122_3344);
    preload(5'd9, 32'h5555_5555);
    drive(1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAA_AA80);
    check("sb_idle_we", 32'(ram_we), 0);
    tick();
    check("sb_write_stall", 32'(stall), 1);
    check("sb_write_ready", 32'(req_ready), 0);
    drive(1'b1, 2'b11, 1'b0, 32'h24, 32'hFFFF_FFFF);
    check("sb_write_we", 32'(ram_we), 1);
    check("sb_write_addr", ram_addr, 32'h10);
    check("sb_write_wdata", ram_wdata, 32'h8022_3344);
    tick();
    idle();
    tick();
    check("sb_mem", mem[4], 32'h8022_3344);
    check("sb_ignored_mem", mem[9], 32'h5555_5555);
    check("sb_stall_done", 32'(stall), 0);
    drive(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    tick();
    check("lb_data", load_data, 32'hFFFF_FF80);
    drive(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    tick();
    check("lbu_data", load_data, 32'h0000_0080);
    drive(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    tick();
    check("lb_lane0", load_data, 32'h0000_0044);

    // SH 0xBEEF @0x22 over zero.
    preload(5'd8, 32'h0);
    drive(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
    tick();
    check("sh_wdata", ram_wdata, 32'hBEEF_0000);
    idle();
    tick();
    check("sh_mem", mem[8], 32'hBEEF_0000);
    drive(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    tick();
    check("lh_data", load_data, 32'hFFFF_BEEF);
    drive(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    tick();
    check("lhu_data", load_data, 32'h0000_BEEF);

    // Misaligned LW @0x06 then SH @0x05.
    preload(5'd1, 32'hCAFE_F00D);
    drive(1'b0, 2'b11, 1'b0, 32'h06, 32'h0);
    tick();
    check("mis_lw_pulse", 32'(misalign), 1);
    check("mis_lw_addr", bad_addr, 32'h06);
    check("mis_lw_no_load", 32'(load_valid), 0);
    drive(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000_FFFF);
    check("mis_sh_we", 32'(ram_we), 0);
    tick();
    check("mis_sh_pulse", 32'(misalign), 1);
    check("mis_sh_addr", bad_addr, 32'h05);
    check("mis_sh_idle", 32'(stall), 0);
    idle();
    tick();
    check("mis_pulse_end", 32'(misalign), 0);
    check("mis_addr_hold", bad_addr, 32'h05);
    check("mis_mem", mem[1], 32'hCAFE_F00D);

    // Reset during the WRITE of SB @0x08.
    preload(5'd2, 32'h0102_0304);
    drive(1'b1, 2'b00, 1'b0, 32'h08, 32'h0000_0099);
    tick();
    check("rstw_we_before", 32'(ram_we), 1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rstw_we", 32'(ram_we), 0);
    check("rstw_stall", 32'(stall), 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_mem", mem[2], 32'h0102_0304);
    check("rstw_ready", 32'(req_ready), 1);

    // Back-to-back loads.
    preload(5'd0, 32'h0BAD_CAFE);
    drive(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    tick();
    check("b2b0_valid", 32'(load_valid), 1);
    check("b2b0_data", load_data, 32'h0BAD_CAFE);
    drive(1'b0, 2'b11, 1'b0, 32'h04, 32'h0);
    tick();
    check("b2b1_valid", 32'(load_valid), 1);
    check("b2b1_data", load_data, 32'hCAFE_F00D);
    drive(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
    tick();
    check("b2b2_valid", 32'(load_valid), 1);
    check("b2b2_data", load_data, 32'h0102_0304);
    idle();
    tick();
    check("b2b_end", 32'(load_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
